// File: rtl/cam_pkg.sv
// Shared types and helpers for the OV7670 capture controller.
package cam_pkg;

  localparam int unsigned WIDTH_DEF  = 176;
  localparam int unsigned HEIGHT_DEF = 144;
  localparam int unsigned ADDR_W_DEF = 15;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS,
    CAPTURE,
    DONE
  } state_t;

  // hi = {R[4:0],G[5:3]}, lo = {G[2:0],B[4:0]} -> {R[4:2],G[5:3],B[4:3]}
  function automatic logic [7:0] rgb565_to_332(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[7:5], hi[2:0], lo[4:3]};
  endfunction

endpackage

// File: rtl/cam_capture_ctrl_if.sv
// Camera pins, consumer handshake and frame-buffer write port of the capture controller.
// Statistics signals exist only when CAM_CAPTURE_STATS_EN is defined.
interface cam_capture_ctrl_if #(
  parameter int unsigned ADDR_W = 15
);
  logic              cam_pclk;
  logic              cam_href;
  logic              cam_vsync;
  logic [7:0]        cam_d;
  logic              arm;
  logic              continuous;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_en;
  logic              busy;
  logic              frame_done;
  logic              frame_err;
`ifdef CAM_CAPTURE_STATS_EN
  logic [9:0]        stat_lines;
  logic [9:0]        stat_pix;

  modport master (
    input  cam_pclk, cam_href, cam_vsync, cam_d, arm, continuous,
    output wr_addr, wr_data, wr_en, busy, frame_done, frame_err, stat_lines, stat_pix
  );
  modport slave (
    output cam_pclk, cam_href, cam_vsync, cam_d, arm, continuous,
    input  wr_addr, wr_data, wr_en, busy, frame_done, frame_err, stat_lines, stat_pix
  );
`else
  modport master (
    input  cam_pclk, cam_href, cam_vsync, cam_d, arm, continuous,
    output wr_addr, wr_data, wr_en, busy, frame_done, frame_err
  );
  modport slave (
    output cam_pclk, cam_href, cam_vsync, cam_d, arm, continuous,
    input  wr_addr, wr_data, wr_en, busy, frame_done, frame_err
  );
`endif
endinterface

// File: rtl/cam_sync_edge.sv
// Two-flop synchroniser with registered level and rise/fall pulses, all aligned.
module cam_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);
  logic s1, s2;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1    <= async_in;
      s2    <= s1;
      level <= s2;
      rise  <= s2 & ~level;
      fall  <= ~s2 & level;
    end
  end
endmodule

// File: rtl/cam_capture_ctrl.sv
// OV7670 frame capture: oversampled camera bus -> RGB332 writes into the frame buffer.
// Optional CAM_CAPTURE_STATS_EN adds per-frame line/pixel statistics.
module cam_capture_ctrl
  import cam_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned HEIGHT = HEIGHT_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  cam_capture_ctrl_if.master bus
);
  localparam int unsigned XW = $clog2(WIDTH + 1);
  localparam int unsigned YW = $clog2(HEIGHT + 1);

  logic pclk_lvl, pclk_rise, pclk_fall;
  logic href_lvl, href_rise, href_fall;
  logic vs_lvl, vs_rise, vs_fall;
  logic [7:0] d_s1, d_s2;

  cam_sync_edge u_sync_pclk (.clk(clk), .reset_n(reset_n), .async_in(bus.cam_pclk),
                             .level(pclk_lvl), .rise(pclk_rise), .fall(pclk_fall));
  cam_sync_edge u_sync_href (.clk(clk), .reset_n(reset_n), .async_in(bus.cam_href),
                             .level(href_lvl), .rise(href_rise), .fall(href_fall));
  cam_sync_edge u_sync_vs   (.clk(clk), .reset_n(reset_n), .async_in(bus.cam_vsync),
                             .level(vs_lvl), .rise(vs_rise), .fall(vs_fall));

  logic unused_edges;
  assign unused_edges = ^{pclk_lvl, pclk_fall, vs_lvl, href_rise};

  // Data bus: plain two-flop sync; stable around PCLK rise because PCLK <= CLK/4
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      d_s1 <= '0;
      d_s2 <= '0;
    end else begin
      d_s1 <= bus.cam_d;
      d_s2 <= d_s1;
    end
  end

  state_t            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic              phase_q, phase_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [7:0]        byte0_q, byte0_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef CAM_CAPTURE_STATS_EN
  logic [9:0]        lines_q, lines_d, pix_q, pix_d;
  logic [9:0]        stat_lines_q, stat_lines_d, stat_pix_q, stat_pix_d;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      phase_q   <= 1'b0;
      base_q    <= '0;
      byte0_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef CAM_CAPTURE_STATS_EN
      lines_q      <= '0;
      pix_q        <= '0;
      stat_lines_q <= '0;
      stat_pix_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      phase_q   <= phase_d;
      base_q    <= base_d;
      byte0_q   <= byte0_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef CAM_CAPTURE_STATS_EN
      lines_q      <= lines_d;
      pix_q        <= pix_d;
      stat_lines_q <= stat_lines_d;
      stat_pix_q   <= stat_pix_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    phase_d   = phase_q;
    base_d    = base_q;
    byte0_d   = byte0_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
`ifdef CAM_CAPTURE_STATS_EN
    lines_d      = lines_q;
    pix_d        = pix_q;
    stat_lines_d = stat_lines_q;
    stat_pix_d   = stat_pix_q;
`endif

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.arm || bus.continuous) begin
          state_d = WAIT_VS;
          busy_d  = 1'b1;
          err_d   = 1'b0;
        end
      end

      WAIT_VS: begin
        if (vs_fall) begin
          state_d = CAPTURE;
          x_d     = '0;
          y_d     = '0;
          phase_d = 1'b0;
          base_d  = '0;
        end
      end

      CAPTURE: begin
        if (vs_rise) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (y_q < YW'(HEIGHT) || href_lvl) err_d = 1'b1;
        end else if (href_fall) begin
          // An odd byte count leaves a half pixel that is discarded
          if (phase_q) err_d = 1'b1;
          x_d     = '0;
          phase_d = 1'b0;
          if (y_q < YW'(HEIGHT)) begin
            y_d    = y_q + YW'(1);
            base_d = base_q + ADDR_W'(WIDTH);
          end
        end else if (pclk_rise && href_lvl) begin
          if (!phase_q) begin
            byte0_d = d_s2;
            phase_d = 1'b1;
          end else begin
            phase_d   = 1'b0;
            wr_data_d = rgb565_to_332(byte0_q, d_s2);
            if (x_q < XW'(WIDTH) && y_q < YW'(HEIGHT)) begin
              wr_addr_d = base_q + ADDR_W'(x_q);
              wr_en_d   = 1'b1;
            end
            if (x_q < XW'(WIDTH)) x_d = x_q + XW'(1);
          end
        end
      end

      DONE: begin
        // ARM seen during the FRAME_DONE cycle re-arms here, one cycle later
        if (bus.arm || bus.continuous) begin
          state_d = WAIT_VS;
          busy_d  = 1'b1;
          err_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

`ifdef CAM_CAPTURE_STATS_EN
    if (state_q == WAIT_VS && vs_fall) begin
      lines_d = '0;
      pix_d   = '0;
    end
    if (state_q == CAPTURE) begin
      if (href_rise) begin
        lines_d = lines_q + 10'd1;
        pix_d   = '0;
      end else if (pclk_rise && href_lvl && phase_q) begin
        pix_d = pix_q + 10'd1;
      end
      if (vs_rise) begin
        stat_lines_d = lines_q;
        stat_pix_d   = pix_q;
      end
    end
`endif
  end

  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.frame_err  = err_q;
`ifdef CAM_CAPTURE_STATS_EN
  assign bus.stat_lines = stat_lines_q;
  assign bus.stat_pix   = stat_pix_q;
`endif

endmodule

// File: doc/cam_capture_ctrl.md
Name: cam_capture_ctrl

Overview:
Sequences OV7670 frame capture into the dual-port M9K frame buffer.
- Oversamples the camera PCLK/HREF/VSYNC/D[7:0] on the system clock.
- Assembles each RGB565 byte pair and packs it to RGB332.
- Generates write address and write-enable for the buffer's write port.
- Handshakes with a consumer (image processor / VGA) via ARM, BUSY and FRAME_DONE.

Parameters:
WIDTH, 176, pixels stored per line; extra pixels in a line are dropped.
HEIGHT, 144, lines stored per frame; extra lines are dropped.
ADDR_W, 15, frame-buffer address width.

Ports:
CLK  in  1  system clock, 50 MHz; camera PCLK must be <= CLK/4.
RESET_N  in  1  synchronous, active-low reset.
CAM_PCLK  in  1  camera pixel clock (asynchronous).
CAM_HREF  in  1  camera line-valid (asynchronous).
CAM_VSYNC  in  1  camera frame sync, high between frames (asynchronous).
CAM_D  in  8  camera data bus (asynchronous).
ARM  in  1  one-cycle request to capture the next full frame.
CONTINUOUS  in  1  level; when high, re-arms automatically after each frame.
WR_ADDR  out  ADDR_W  buffer write address (x + y*WIDTH).
WR_DATA  out  8  RGB332 pixel.
WR_EN  out  1  one-cycle write strobe.
BUSY  out  1  high from accepted ARM until FRAME_DONE.
FRAME_DONE  out  1  one-cycle pulse at end of a capture.
FRAME_ERR  out  1  sticky until next accepted ARM; set on any abnormal frame.

Behaviour:
- Reset values: WR_ADDR=0, WR_DATA=0, WR_EN=0, BUSY=0, FRAME_DONE=0, FRAME_ERR=0, state IDLE.
- RESET_N low mid-frame: state returns to IDLE on that edge; no further WR_EN.
- Synchronisation: PCLK, HREF, VSYNC and D each pass through 2 flops.
- PCLK edge: "pclk_rise" = synced PCLK is 1 and its previous value was 0. HREF/VSYNC edges are detected the same way.
- State IDLE: BUSY=0. ARM, or CONTINUOUS=1, moves to WAIT_VS.
  - On acceptance: clear FRAME_ERR, set BUSY.
- State WAIT_VS: wait for a VSYNC falling edge, so capture always starts on a frame boundary.
  - Then clear x, y, byte-phase and line base; go to CAPTURE.
- State CAPTURE, on each pclk_rise with HREF=1:
  - Phase 0: latch the byte as {R[4:0],G[5:3]}.
  - Phase 1: form WR_DATA={R[4:2],G[5:3],B[4:3]} from the second byte {G[2:0],B[4:0]}.
  - Phase 1, when x<WIDTH and y<HEIGHT: WR_ADDR=line_base+x, WR_EN=1 on the next cycle.
  - Phase 1: x increments, saturating at WIDTH.
- HREF falling edge in CAPTURE:
  - If phase=1 (odd byte count): drop the byte and set FRAME_ERR.
  - Reset x and phase to 0.
  - If y<HEIGHT: y+1 and line_base+=WIDTH. Never use a multiplier.
- VSYNC rising edge in CAPTURE goes to DONE.
  - If fewer than HEIGHT lines were seen: set FRAME_ERR.
  - If HREF is high at that moment: set FRAME_ERR; the partial line is kept.
- State DONE (1 cycle): FRAME_DONE=1, BUSY=0. Then go to IDLE, or WAIT_VS if CONTINUOUS=1.
- ARM while BUSY is ignored. ARM arriving in the same cycle as FRAME_DONE is accepted next cycle.
- Latency: WR_EN is asserted 4 CLK cycles after the PCLK rising edge at the pin (2 sync + 1 edge detect + 1 output register).
- WR_EN is never high for two consecutive cycles.
- Address arithmetic is unsigned, ADDR_W wide. WIDTH*HEIGHT must be <= 2^ADDR_W.

Optional Feature:
CAM_CAPTURE_STATS_EN: adds outputs STAT_LINES[9:0] and STAT_PIX[9:0].
- STAT_LINES: HREF pulses in the last frame, unclamped.
- STAT_PIX: pixels in the last line of that frame, unclamped.
- Both update at FRAME_DONE.
Without the macro these ports and their counters do not exist. Core behaviour is identical either way.

Decomposition:
- Shared package cam_pkg: state enum (IDLE, WAIT_VS, CAPTURE, DONE), default WIDTH/HEIGHT constants, RGB565-to-RGB332 packing function.
- One sub-module, cam_sync_edge: 2-flop synchroniser plus rise/fall detector. Instantiated for PCLK, HREF, VSYNC.
- The data bus uses plain 2-flop sync inside the top.

Test Plan:
- Reset mid-capture (RESET_N low 1 cycle during line 5) -> next cycle WR_EN=0, BUSY=0, state IDLE; no writes until a new ARM.
- ARM, then a 176x144 frame of constant bytes 0xF8,0x00 -> 25344 writes, data 0xE0, last WR_ADDR=25343, one FRAME_DONE, FRAME_ERR=0.
- Lines of 180 pixels, 150 lines -> exactly 176x144 writes, addresses 0..25343; extra pixels/lines dropped, FRAME_ERR=0.
- ARM, then a line with 351 bytes (odd count) -> last byte dropped, FRAME_ERR=1 after FRAME_DONE; next ARM clears it.
- VSYNC rises after 100 lines -> FRAME_DONE, FRAME_ERR=1, highest WR_ADDR=17599.
- CONTINUOUS=1 across 3 frames, with ARM pulsed while BUSY -> 3 FRAME_DONE pulses, no extra capture.
- ARM issued mid-frame -> first write occurs only after the next VSYNC fall, at WR_ADDR=0.
